tsc_pretrig_cache: RTL and testbench

Parametrised trigger-surround cache that captures a window of ADC samples around a trigger event: a programmable number of pre-trigger samples, the trigger sample, and the post-trigger remainder of a power-of-two ring buffer. It sits between the ADC sample interface and the serial uplink. After capture it timestamps the trigger and, on request, streams the window oldest-first as a serial bit stream.

---
 rtl/tsc_pretrig_cache_if.sv | 36 +++
 rtl/tsc_pretrig_cache.sv | 234 +++++++++++++++++++++++
 tb/tb_tsc_pretrig_cache.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tsc_pretrig_cache_if.sv
// -----------------------------------------------------------------------------
// tsc_pretrig_cache_if
// Bundles the control, sample and serial-uplink signals of tsc_pretrig_cache.
//   master : drives start/abort/send, the sample stream and the trigger setup
//   slave  : the cache itself; returns status, timestamp and the serial stream
// Parameters: DATA_W (sample width), TIMER_W (timestamp width)
// -----------------------------------------------------------------------------
interface tsc_pretrig_cache_if #(
  parameter int DATA_W  = 8,
  parameter int TIMER_W = 32
);
  logic               start;
  logic               abort;
  logic               smp_vld;
  logic [DATA_W-1:0]  smp_data;
  logic [DATA_W-1:0]  trig_lvl;
  logic               trig_edge;
  logic               send;
  logic               busy;
  logic               armed;
  logic               trd;
  logic [TIMER_W-1:0] trigtm;
  logic               cd;
  logic               sd;
  logic               sd_vld;

  modport master (
    output start, abort, smp_vld, smp_data, trig_lvl, trig_edge, send,
    input  busy, armed, trd, trigtm, cd, sd, sd_vld
  );

  modport slave (
    input  start, abort, smp_vld, smp_data, trig_lvl, trig_edge, send,
    output busy, armed, trd, trigtm, cd, sd, sd_vld
  );
endinterface

// File: rtl/tsc_pretrig_cache.sv
// -----------------------------------------------------------------------------
// tsc_pretrig_cache
// Trigger-surround cache: keeps PRE samples before a trigger, the trigger
// sample and DEPTH-PRE-1 samples after it in a DEPTH-entry ring, timestamps
// the trigger and streams the window oldest-first, MSB first, on request.
//
// Ports
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : tsc_pretrig_cache_if.slave
//            in : start, abort, smp_vld, smp_data, trig_lvl, trig_edge, send
//            out: busy, armed, trd, trigtm, cd, sd, sd_vld
//
// Build option
//   TSC_PARITY_EN : when defined, each serial word gets one even-parity bit
//                   after its LSB (word length DATA_W+1 instead of DATA_W).
//
// Requires DEPTH a power of two >= 4, 0 <= PRE <= DEPTH-1 and a serial word
// of at least two bits (the next word is prefetched while the current one
// shifts out).
// -----------------------------------------------------------------------------
module tsc_pretrig_cache #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int PRE     = 16,
  parameter int TIMER_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  tsc_pretrig_cache_if.slave  bus
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int POST_N = DEPTH - PRE - 1;
`ifdef TSC_PARITY_EN
  localparam int B      = DATA_W + 1;
`else
  localparam int B      = DATA_W;
`endif
  localparam int BW     = $clog2(B + 1);

  localparam logic [AW-1:0] PRE_A     = AW'(PRE);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'((PRE    == 0) ? 0 : PRE - 1);
  localparam logic [CW-1:0] POST_LAST = CW'((POST_N == 0) ? 0 : POST_N - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(B - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREFILL, S_ARMED, S_POST, S_DONE, S_SEND
  } state_t;

  state_t              r_state;
  logic [TIMER_W-1:0]  r_timer;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_base;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_cnt;
  logic [AW-1:0]       r_word_cnt;
  logic [BW-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]   r_prev;
  logic                r_trd;
  logic [TIMER_W-1:0]  r_trigtm;
  logic                r_cd;
  logic [B-1:0]        r_shift;
  logic                r_sd_vld;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_capture;
  logic                w_wr_en;
  logic                w_trig;
  logic [AW-1:0]       w_rd_addr;
  logic [B-1:0]        w_word;

  // States in which incoming samples land in the ring.
  assign w_capture = (r_state == S_PREFILL) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_wr_en   = w_capture && bus.smp_vld && !bus.abort;

  // Level: at or above threshold. Edge: additionally the previous sample was below.
  assign w_trig = (bus.smp_data >= bus.trig_lvl) &&
                  (!bus.trig_edge || (r_prev < bus.trig_lvl));

  // Read address keeps the first dump word prefetched before send arrives:
  // while ARMED it tracks the would-be window start, so the data register is
  // correct even when the trigger moves straight to DONE; during SEND it runs
  // one word ahead of the shifter.
  always_comb begin
    w_rd_addr = r_rd_base;
    if (r_state == S_ARMED)
      w_rd_addr = r_wr_ptr - PRE_A;
    else if (r_state == S_SEND)
      w_rd_addr = r_rd_ptr;
  end

`ifdef TSC_PARITY_EN
  assign w_word = {r_rd_data, ^r_rd_data};
`else
  assign w_word = r_rd_data;
`endif

  // Ring storage: no reset so it maps onto block RAM; contents are don't-care
  // after reset.
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr] <= bus.smp_data;
    r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_wr_ptr   <= '0;
      r_rd_base  <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_word_cnt <= '0;
      r_bit_cnt  <= '0;
      r_prev     <= '0;
      r_trd      <= 1'b0;
      r_trigtm   <= '0;
      r_cd       <= 1'b0;
      r_shift    <= '0;
      r_sd_vld   <= 1'b0;
    end else begin
      r_timer <= r_timer + TIMER_W'(1);

      if (bus.abort) begin
        r_state  <= S_IDLE;
        r_trd    <= 1'b0;
        r_cd     <= 1'b0;
        r_shift  <= '0;
        r_sd_vld <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_wr_ptr   <= '0;
              r_cnt      <= '0;
              r_word_cnt <= '0;
              r_bit_cnt  <= '0;
              r_trd      <= 1'b0;
              r_cd       <= 1'b0;
              r_trigtm   <= '0;
              r_prev     <= '1;
              r_state    <= (PRE == 0) ? S_ARMED : S_PREFILL;
            end
          end

          S_PREFILL: begin
            if (bus.smp_vld) begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
              r_prev   <= bus.smp_data;
              if (r_cnt == PRE_LAST) begin
                r_cnt   <= '0;
                r_state <= S_ARMED;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end

          S_ARMED: begin
            if (bus.smp_vld) begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
              r_prev   <= bus.smp_data;
              if (w_trig) begin
                r_trd     <= 1'b1;
                r_trigtm  <= r_timer;
                r_rd_base <= r_wr_ptr - PRE_A;
                r_cnt     <= '0;
                r_state   <= (POST_N == 0) ? S_DONE : S_POST;
              end
            end
          end

          S_POST: begin
            if (bus.smp_vld) begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
              r_prev   <= bus.smp_data;
              if (r_cnt == POST_LAST)
                r_state <= S_DONE;
              else
                r_cnt <= r_cnt + CW'(1);
            end
          end

          S_DONE: begin
            if (bus.send) begin
              r_shift    <= w_word;
              r_sd_vld   <= 1'b1;
              r_rd_ptr   <= r_rd_base + AW'(1);
              r_word_cnt <= '0;
              r_bit_cnt  <= '0;
              r_state    <= S_SEND;
            end
          end

          S_SEND: begin
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              if (r_word_cnt == LAST_WORD) begin
                r_shift  <= '0;
                r_sd_vld <= 1'b0;
                r_cd     <= 1'b1;
                r_state  <= S_IDLE;
              end else begin
                r_word_cnt <= r_word_cnt + AW'(1);
                r_shift    <= w_word;
                r_rd_ptr   <= r_rd_ptr + AW'(1);
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
              r_shift   <= {r_shift[B-2:0], 1'b0};
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.armed  = (r_state == S_ARMED);
  assign bus.trd    = r_trd;
  assign bus.trigtm = r_trigtm;
  assign bus.cd     = r_cd;
  assign bus.sd     = r_shift[B-1];
  assign bus.sd_vld = r_sd_vld;

endmodule

// File: tb/tb_tsc_pretrig_cache.sv
// -----------------------------------------------------------------------------
// tb_tsc_pretrig_cache
// Directed and randomized checks of tsc_pretrig_cache (DATA_W=8, DEPTH=8,
// PRE=3). A queue-based model records every accepted sample since start,
// finds the trigger index from the threshold rules and slices the expected
// dump window from that history.
// -----------------------------------------------------------------------------
module tb_tsc_pretrig_cache;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 8;
  localparam int PRE     = 3;
  localparam int TIMER_W = 32;
`ifdef TSC_PARITY_EN
  localparam int B = DATA_W + 1;
`else
  localparam int B = DATA_W;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tsc_pretrig_cache_if #(.DATA_W(DATA_W), .TIMER_W(TIMER_W)) bus();

  tsc_pretrig_cache #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PRE(PRE), .TIMER_W(TIMER_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running reference timer: value seen at a negedge is the timer value
  // the DUT holds at the following rising edge.
  logic [TIMER_W-1:0] cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0]         hist[$];
  logic [7:0]         exp_win[$];
  logic [7:0]         got[$];
  int                 tidx;
  logic [TIMER_W-1:0] exp_tm;
  logic [7:0]         m_lvl;
  bit                 m_edge;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_done();
    return (tidx >= 0) && (hist.size() == tidx + DEPTH - PRE);
  endfunction

  task automatic begin_capture(input logic [7:0] lvl, input bit edg,
                               input bit stray, input logic [7:0] stray_d);
    m_lvl = lvl; m_edge = edg;
    bus.trig_lvl  = lvl;
    bus.trig_edge = edg;
    bus.start     = 1'b1;
    bus.smp_vld   = stray;
    bus.smp_data  = stray_d;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.smp_vld = 1'b0;
    hist.delete();
    tidx = -1;
    check("start_busy",  bus.busy,  1'b1);
    check("start_armed", bus.armed, (PRE == 0));
    check("start_trd",   bus.trd,   1'b0);
    check("start_cd",    bus.cd,    1'b0);
  endtask

  task automatic feed(input logic [7:0] d, input bit gap);
    logic [TIMER_W-1:0] tm;
    logic [7:0] prevv;
    int idx;
    if (gap) @(negedge clk);
    bus.smp_vld  = 1'b1;
    bus.smp_data = d;
    tm = cyc;
    @(negedge clk);
    bus.smp_vld = 1'b0;
    if (!model_done()) begin
      hist.push_back(d);
      idx = hist.size() - 1;
      if (tidx < 0 && idx >= PRE) begin
        prevv = (idx == 0) ? 8'hFF : hist[idx-1];
        if (d >= m_lvl && (!m_edge || prevv < m_lvl)) begin
          tidx   = idx;
          exp_tm = tm;
        end
      end
    end
    check("feed_trd",   bus.trd,   (tidx >= 0));
    check("feed_armed", bus.armed, (hist.size() >= PRE) && (tidx < 0));
    check("feed_busy",  bus.busy,  1'b1);
    if (tidx >= 0) check("feed_trigtm", bus.trigtm, exp_tm);
  endtask

  task automatic set_window_from_model();
    exp_win.delete();
    for (int i = 0; i < DEPTH; i++) exp_win.push_back(hist[tidx - PRE + i]);
  endtask

  task automatic do_dump(input string tag);
    int nv;
    int bc;
    logic [B-1:0] acc;
    got.delete();
    bus.send = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
    nv = 0; bc = 0; acc = '0;
    for (int k = 0; k < DEPTH*B + 8; k++) begin
      if (bus.sd_vld !== 1'b1) break;
      nv++;
      acc = {acc[B-2:0], bus.sd};
      bc++;
      if (bc == B) begin
`ifdef TSC_PARITY_EN
        check({tag, "_parity"}, acc[0], ^acc[B-1:1]);
        got.push_back(acc[B-1:1]);
`else
        got.push_back(acc);
`endif
        bc = 0;
      end
      @(negedge clk);
    end
    check({tag, "_vld_cycles"}, nv, DEPTH*B);
    check({tag, "_cd"},     bus.cd,     1'b1);
    check({tag, "_busy"},   bus.busy,   1'b0);
    check({tag, "_trd"},    bus.trd,    1'b1);
    check({tag, "_trigtm"}, bus.trigtm, exp_tm);
    check({tag, "_words"},  got.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < got.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got[i], exp_win[i]);
    $display("dump %s: %0d words, %0d sd_vld cycles, trigtm %0h", tag, got.size(), nv, bus.trigtm);
  endtask

  task automatic random_capture(input string tag);
    logic [7:0] d;
    begin_capture(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 1'b0, 8'h00);
    for (int k = 0; k < 300 && !model_done(); k++) begin
      if (k >= 60 && tidx < 0) d = (k % 2 == 0) ? 8'h00 : 8'hFF;
      else                     d = 8'($urandom_range(0, 255));
      feed(d, ($urandom_range(0, 3) == 0));
    end
    feed(8'($urandom_range(0, 255)), 1'b0);   // lands in DONE, must be ignored
    check({tag, "_done_armed"}, bus.armed, 1'b0);
    set_window_from_model();
    $display("capture %s: lvl %0h edge %0d trigger index %0d", tag, m_lvl, m_edge, tidx);
    do_dump(tag);
  endtask

  initial begin
    int nv;
    bus.start = 0; bus.abort = 0; bus.smp_vld = 0; bus.smp_data = 0;
    bus.trig_lvl = 0; bus.trig_edge = 0; bus.send = 0;
    tidx = -1; exp_tm = '0; m_lvl = 0; m_edge = 0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy",   bus.busy,   1'b0);
    check("rst_armed",  bus.armed,  1'b0);
    check("rst_trd",    bus.trd,    1'b0);
    check("rst_cd",     bus.cd,     1'b0);
    check("rst_trigtm", bus.trigtm, '0);
    check("rst_sd",     bus.sd,     1'b0);
    check("rst_sd_vld", bus.sd_vld, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // level trigger, stray sample alongside start, timestamp at 0x123
    begin_capture(8'h06, 1'b0, 1'b1, 8'h0F);
    for (int v = 1; v <= 5; v++) feed(8'(v), 1'b0);
    for (int k = 0; k < 1000 && cyc != 32'h123; k++) @(negedge clk);
    check("lvl_timer_reached", cyc, 32'h123);
    feed(8'h06, 1'b0);
    check("lvl_trigtm_0x123", bus.trigtm, 32'h123);
    for (int v = 7; v <= 12; v++) feed(8'(v), 1'b0);
    exp_win.delete();
    for (int v = 3; v <= 10; v++) exp_win.push_back(8'(v));
    do_dump("level");
    check("lvl_trigtm_held", bus.trigtm, 32'h123);

    // abort in IDLE clears cd
    bus.abort = 1'b1; @(negedge clk); bus.abort = 1'b0;
    check("idle_abort_cd", bus.cd, 1'b0);

    // edge trigger; start during POST must be ignored
    begin_capture(8'h40, 1'b1, 1'b0, 8'h00);
    feed(8'h80, 1'b0); feed(8'h80, 1'b0); feed(8'h80, 1'b0);
    feed(8'h80, 1'b0); feed(8'h20, 1'b1); feed(8'h50, 1'b0);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    check("edge_start_ignored_trd",  bus.trd,  1'b1);
    check("edge_start_ignored_busy", bus.busy, 1'b1);
    for (int k = 0; k < 20 && !model_done(); k++) feed(8'($urandom_range(0, 255)), 1'b0);
    set_window_from_model();
    do_dump("edge");
    if (got.size() > 3) check("edge_idx3", got[3], 8'h50);
    else                check("edge_idx3_present", got.size(), 4);

    // abort during POST
    begin_capture(8'h00, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 6; k++) feed(8'($urandom_range(0, 255)), 1'b0);
    check("abort_pre_trd", bus.trd, 1'b1);
    bus.abort = 1'b1; @(negedge clk); bus.abort = 1'b0;
    check("abort_busy",   bus.busy,   1'b0);
    check("abort_trd",    bus.trd,    1'b0);
    check("abort_cd",     bus.cd,     1'b0);
    check("abort_sd_vld", bus.sd_vld, 1'b0);
    bus.send = 1'b1; @(negedge clk); bus.send = 1'b0;
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.sd_vld === 1'b1) nv++;
      @(negedge clk);
    end
    check("abort_send_vld_cycles", nv, 0);
    check("abort_send_cd",   bus.cd,   1'b0);
    check("abort_send_busy", bus.busy, 1'b0);
    $display("abort: busy %0d trd %0d cd %0d sd_vld cycles %0d", bus.busy, bus.trd, bus.cd, nv);

    // randomized captures
    for (int r = 0; r < 6; r++) random_capture($sformatf("rand%0d", r));

    // reset in the middle of SEND, at the 10th bit
    begin_capture(8'h10, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 20 && !model_done(); k++) feed(8'hFF, 1'b0);
    bus.send = 1'b1; @(negedge clk); bus.send = 1'b0;
    repeat (9) @(negedge clk);
    check("midsend_vld_before", bus.sd_vld, 1'b1);
    check("midsend_sd_before",  bus.sd,     1'b1);
    #1 reset = 1'b1;
    #1;
    check("midsend_sd",     bus.sd,     1'b0);
    check("midsend_sd_vld", bus.sd_vld, 1'b0);
    check("midsend_cd",     bus.cd,     1'b0);
    check("midsend_trd",    bus.trd,    1'b0);
    check("midsend_busy",   bus.busy,   1'b0);
    $display("reset mid-send: sd %0d sd_vld %0d cd %0d trd %0d", bus.sd, bus.sd_vld, bus.cd, bus.trd);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    random_capture("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
